alu_seq_hs: RTL and testbench
=============================

Name: alu_seq_hs

Overview:
Parametrised successor to the team's 4-bit combinational ALU, which uses a 3-bit opcode and carry/overflow/sign/zero/parity flags. This block adds WIDTH generalisation, registered outputs and valid/ready handshakes on both sides. It also adds a multi-cycle shift-add multiply that the old ALU lacks. It sits between an operand source (e.g. register-file read stage) and a result sink, with one operation in flight at a time.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), multiply iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept an operation
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  3  opcode
out_valid  output  1  result/flags valid
out_ready  input  1  sink accepts result
out_result  output  WIDTH  result
out_carry  output  1  carry/borrow/shift-out/mul-high flag
out_overflow  output  1  signed overflow (ADD/SUB only)
out_sign  output  1  out_result[WIDTH-1]
out_zero  output  1  out_result == 0
out_parity  output  1  XOR-reduction of out_result (1 = odd count of ones)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: IDLE. in_ready=1, out_valid=0, out_result and all flags 0.
- Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 MUL (low WIDTH bits of A*B, unsigned), 111 ROL A by 1.
- Flags, carry:
  - ADD: carry-out.
  - SUB: borrow (1 when A<B unsigned).
  - ROL: the bit rotated out of the MSB.
  - MUL: 1 if the upper WIDTH product bits are nonzero.
  - Logic ops: 0.
- Flags, overflow: signed two's-complement overflow for ADD/SUB; 0 otherwise.
- Flags, sign/zero/parity: derived from the registered result. All flags are registered together with the result.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_a/in_b/in_op. Opcode != 110 computes and registers result, then goes to DONE (latency 1 cycle). Opcode 110 clears the product accumulator, sets counter=0, goes to MUL.
  - MUL: one shift-add step per cycle, WIDTH cycles. After step WIDTH-1, register result/flags and go to DONE. Acceptance-to-out_valid latency is WIDTH+1 cycles.
  - DONE: out_valid=1. Result/flags held stable until out_valid&&out_ready, then go to IDLE. in_ready=0 in MUL and DONE; no combinational ready path.
- Throughput: at most one operation per 2 cycles, one per WIDTH+2 cycles for MUL.
- Boundaries:
  - Input changes while in MUL/DONE are ignored; operands come only from the latched copy.
  - out_ready high while not in DONE has no effect.
  - rst in any state (including mid-MUL) aborts the operation next edge and returns to the reset state.
  - ROL of all-zeros sets zero=1, carry=0.

Optional Feature:
ALU_ACC_EN
- Defined: adds input port in_acc (1 bit), sampled at acceptance. When in_acc=1, operand A is replaced by the last completed out_result; in_a is ignored. The accumulator resets to 0 on rst and updates on every completion.
- Undefined: the port and accumulator register do not exist; behaviour is exactly as above.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams/enum (OP_ADD..OP_ROL)
  - FSM state enum (ST_IDLE, ST_MUL, ST_DONE)
  - flag bundle struct (carry, overflow, sign, zero, parity)
- Sub-module alu_mul_seq: iterative shift-add multiplier with start/done, WIDTH parameter, 2*WIDTH product. The top FSM drives start and consumes done.

Test Plan:
All with WIDTH=8.
1. ADD 0x7F+0x01 -> out_valid 1 cycle after accept, result 0x80, C=0 V=1 S=1 Z=0 P=1.
2. SUB 0x05-0x0B -> result 0xFA, C=1 V=0 S=1 Z=0 P=0; then XOR 0x55^0x55 -> 0x00, Z=1 P=0.
3. MUL 0x10*0x11 -> result 0x10, C=1, V=0; out_valid exactly 9 cycles after accept; in_ready=0 throughout.
4. Backpressure: after ROL 0x81 -> result 0x03, C=1, hold out_ready=0 for 5 cycles with in_valid=1 and changing in_a. Result stays 0x03, no accept, in_ready=0. Release out_ready -> IDLE next cycle, then the pending op is accepted.
5. Reset mid-MUL: assert rst 3 cycles after MUL accept -> next cycle out_valid=0, in_ready=1, result/flags 0. A following ADD 0x02+0x03 returns 0x05.
6. ALU_ACC_EN defined: ADD 0x05+0x03 -> 0x08; then in_acc=1, in_b=0x02, ADD -> 0x0A; rst -> accumulator 0, in_acc=1 ADD b=0x01 -> 0x01. Macro undefined: build has no in_acc port.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential handshake ALU.
//   op_e        - 3-bit opcode encoding (OP_ADD .. OP_ROL)
//   state_e     - top-level FSM states (ST_IDLE, ST_MUL, ST_DONE)
//   alu_flags_t - flag bundle registered alongside the result
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_MUL = 3'b110,
    OP_ROL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic sign;
    logic zero;
    logic parity;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one partial product per cycle,
// WIDTH steps per operation.
//   clk, rst   - clock, synchronous active-high reset (control state only)
//   start_i    - load operands and clear the accumulator
//   a_i, b_i   - multiplicand / multiplier
//   done_o     - high during the cycle in which the final step is taken
//   product_o  - accumulator value after the current step; the full 2*WIDTH
//                product is valid while done_o is high
module alu_mul_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               last_step;

  // Multiplicand shifts left and multiplier shifts right each step, so the
  // current multiplier LSB always selects the correctly weighted addend.
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_step = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign done_o    = last_step;
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (last_step) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/alu_seq_hs.sv
// alu_seq_hs: registered WIDTH-bit ALU with valid/ready handshakes on both
// sides and a multi-cycle shift-add multiply. One operation in flight.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake (in_ready only in IDLE)
//   in_a, in_b, in_op   - operands and 3-bit opcode
//   out_valid/out_ready - result handshake (out_valid only in DONE)
//   out_result          - registered result
//   out_carry, out_overflow, out_sign, out_zero, out_parity - registered flags
// Optional build macro ALU_ACC_EN adds in_acc: when set at acceptance,
// operand A is taken from the last completed result instead of in_a.
module alu_seq_hs
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_parity
`ifdef ALU_ACC_EN
  ,
  input  logic             in_acc
`endif
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  alu_flags_t           flags_q, flags_d;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH+1:0]     alu_out;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  // Returns {carry, overflow, result} for every single-cycle opcode.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input op_e op);
    logic [WIDTH:0]          wide;
    logic [WIDTH-1:0]        r;
    logic signed [WIDTH-1:0] sa, sb, sr;
    logic                    c, v;
    wide = '0;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    sa   = a;
    sb   = b;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        sr   = r;
        v    = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
      end
      OP_SUB: begin
        // The extra MSB of the widened difference is the borrow.
        wide = {1'b0, a} - {1'b0, b};
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        sr   = r;
        v    = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_ROL: begin
        r = {a[WIDTH-2:0], a[WIDTH-1]};
        c = a[WIDTH-1];
      end
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  function automatic alu_flags_t mk_flags(input logic [WIDTH-1:0] r,
                                          input logic c,
                                          input logic v);
    alu_flags_t f;
    f.carry    = c;
    f.overflow = v;
    f.sign     = r[WIDTH-1];
    f.zero     = (r == '0);
    f.parity   = ^r;
    return f;
  endfunction

`ifdef ALU_ACC_EN
  logic [WIDTH-1:0] acc_q;
  assign op_a = in_acc ? acc_q : in_a;

  always_ff @(posedge clk) begin
    if (rst)                         acc_q <= '0;
    else if (out_valid && out_ready) acc_q <= result_q;
  end
`else
  assign op_a = in_a;
`endif

  assign alu_out = alu_eval(op_a, in_b, op_e'(in_op));

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (op_a),
    .b_i       (in_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op_e'(in_op) == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            result_d = alu_out[WIDTH-1:0];
            flags_d  = mk_flags(alu_out[WIDTH-1:0], alu_out[WIDTH+1], alu_out[WIDTH]);
            state_d  = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        // Capture on the final step itself so the product lands without an
        // extra cycle of delay.
        if (mul_done) begin
          result_d = mul_prod[WIDTH-1:0];
          flags_d  = mk_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign out_result   = result_q;
  assign out_carry    = flags_q.carry;
  assign out_overflow = flags_q.overflow;
  assign out_sign     = flags_q.sign;
  assign out_zero     = flags_q.zero;
  assign out_parity   = flags_q.parity;

endmodule

// File: tb/tb_alu_seq_hs.sv
// tb_alu_seq_hs: directed and randomized bench for alu_seq_hs (WIDTH=8).
// With ALU_ACC_EN defined the accumulator scenario is exercised as well.
module tb_alu_seq_hs;

  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry, out_overflow, out_sign, out_zero, out_parity;
`ifdef ALU_ACC_EN
  logic         in_acc;
`endif

  int nchk = 0;
  int nerr = 0;
  int model_acc = 0;
  logic acc_sel = 1'b0;

  alu_seq_hs #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_sign     (out_sign),
    .out_zero     (out_zero),
    .out_parity   (out_parity)
`ifdef ALU_ACC_EN
    ,
    .in_acc       (in_acc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs_flags();
    return {out_carry, out_overflow, out_sign, out_zero, out_parity};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: integers, not bit vectors.
  function automatic void ref_model(input int a, input int b, input int op,
                                    output int res, output logic [4:0] fl);
    int s, sa, sb, ss, ones, t;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    case (op)
      0: begin s = a + b; c = (s >= MOD); ss = sa + sb; v = (ss >= HALF) || (ss < -HALF); end
      1: begin s = a - b + MOD; c = (a < b); ss = sa - sb; v = (ss >= HALF) || (ss < -HALF); end
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
      5: s = (MOD - 1) - a;
      6: begin s = a * b; c = (s >= MOD); end
      default: begin s = a * 2 + a / HALF; c = (a >= HALF); end
    endcase
    res = s % MOD;
    ones = 0;
    t = res;
    for (int i = 0; i < W; i++) begin
      ones += t % 2;
      t = t / 2;
    end
    fl = {c, v, (res >= HALF), (res == 0), (ones % 2 == 1)};
  endfunction

  // Present one operation, return cycles from acceptance to out_valid.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
`ifdef ALU_ACC_EN
    in_acc = acc_sel;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("ready_low_busy", in_ready, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_drain", {in_ready, out_valid}, 2'b10);
  endtask

  task automatic dir_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [W-1:0] exp_res,
                        input logic [4:0] exp_fl, input int exp_lat);
    int lat;
    issue(a, b, op, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, out_result, exp_res);
    check({tag, "_flags"}, obs_flags(), exp_fl);
    model_acc = out_result;
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_acc = 0;
  endtask

  initial begin
    int lat, res, opa, ra, rb, rop, hold;
    logic [4:0] fl;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
`ifdef ALU_ACC_EN
    in_acc = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_hs", {in_ready, out_valid}, 2'b10);
    check("rst_res", out_result, 0);
    check("rst_flags", obs_flags(), 0);
    rst = 1'b0;

    // Flags ordered C V S Z P.
    dir_op("add_ovf", 8'h7F, 8'h01, 3'b000, 8'h80, 5'b01101, 1);
    dir_op("sub_borrow", 8'h05, 8'h0B, 3'b001, 8'hFA, 5'b10100, 1);
    dir_op("xor_zero", 8'h55, 8'h55, 3'b100, 8'h00, 5'b00010, 1);
    dir_op("mul", 8'h10, 8'h11, 3'b110, 8'h10, 5'b10001, 9);
    dir_op("rol_zero", 8'h00, 8'h00, 3'b111, 8'h00, 5'b00010, 1);

    // Backpressure with changing inputs while DONE.
    issue(8'h81, 8'h00, 3'b111, lat);
    check("bp_rol_res", out_result, 8'h03);
    check("bp_rol_flags", obs_flags(), 5'b10000);
    in_valid = 1'b1; in_op = 3'b000; in_b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      in_a = 8'(i * 37 + 1);
      @(posedge clk); #1;
      check("bp_hold_res", out_result, 8'h03);
      check("bp_hold_hs", {in_ready, out_valid}, 2'b01);
    end
    in_a = 8'h11;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_idle", {in_ready, out_valid}, 2'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_pending_res", {out_valid, out_result}, {1'b1, 8'h33});
    model_acc = 'h33;
    drain();

    // Reset mid-multiply.
    in_a = 8'h0F; in_b = 8'h0F; in_op = 3'b110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mul_busy_hs", {in_ready, out_valid}, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_acc = 0;
    check("midmul_rst_hs", {in_ready, out_valid}, 2'b10);
    check("midmul_rst_res", out_result, 0);
    check("midmul_rst_flags", obs_flags(), 0);
    dir_op("add_after_rst", 8'h02, 8'h03, 3'b000, 8'h05, 5'b00000, 1);

`ifdef ALU_ACC_EN
    dir_op("acc_base", 8'h05, 8'h03, 3'b000, 8'h08, 5'b00001, 1);
    acc_sel = 1'b1;
    dir_op("acc_use", 8'hEE, 8'h02, 3'b000, 8'h0A, 5'b00000, 1);
    acc_sel = 1'b0;
    do_reset();
    acc_sel = 1'b1;
    dir_op("acc_after_rst", 8'hEE, 8'h01, 3'b000, 8'h01, 5'b00001, 1);
    acc_sel = 1'b0;
`endif

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      ra  = $urandom_range(0, MOD - 1);
      rb  = $urandom_range(0, MOD - 1);
      rop = $urandom_range(0, 7);
      if (n % 8 == 0) ra = MOD - 1;
      if (n % 8 == 1) rb = 0;
`ifdef ALU_ACC_EN
      acc_sel = ($urandom_range(0, 3) == 0);
`endif
      opa = acc_sel ? model_acc : ra;
      ref_model(opa, rb, rop, res, fl);
      issue(W'(ra), W'(rb), 3'(rop), lat);
      check("rnd_lat", lat, (rop == 6) ? W + 1 : 1);
      check("rnd_res", out_result, res);
      check("rnd_flags", obs_flags(), fl);
      hold = $urandom_range(0, 2);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check("rnd_hold", {out_valid, out_result}, {1'b1, W'(res)});
      end
      model_acc = res;
      drain();
    end
    acc_sel = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
